alu_console: RTL and testbench

Board-level operator front-end for ALU bring-up on DE-series hardware under DESim. Debounces the pushbuttons and walks a state machine that gathers operands A, B and an opcode from the switches byte by byte. It then issues a single start/done transaction to a downstream ALU and shows each field, the result or an error on HEX5..HEX0, with flags on LEDR. It generalises the fixed-width ALU test top to parametrised operand width, debounce and a handshaked ALU with timeout.

---
 rtl/alu_console_pkg.sv | 92 +++++++++
 rtl/alu_console_key_debounce.sv | 62 ++++++
 rtl/alu_console.sv | 172 +++++++++++++++++
 tb/tb_alu_console.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_console_pkg.sv
// Shared types and constants for the ALU bring-up console: FSM states, the
// one-hot LEDR state map, key indices and the 7-segment encodings.
package alu_console_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A  = 3'd0,
    ST_LOAD_B  = 3'd1,
    ST_LOAD_OP = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // Bit positions within the raw key_n bus.
  localparam int KEY_ENTER = 0;
  localparam int KEY_NEXT  = 1;
  localparam int KEY_CLEAR = 2;
  localparam int NUM_KEYS  = 3;

  // One-hot state map shown on LEDR[9:4].
  localparam logic [5:0] LED_LOAD_A  = 6'b000001;
  localparam logic [5:0] LED_LOAD_B  = 6'b000010;
  localparam logic [5:0] LED_LOAD_OP = 6'b000100;
  localparam logic [5:0] LED_EXEC    = 6'b001000;
  localparam logic [5:0] LED_SHOW    = 6'b010000;
  localparam logic [5:0] LED_ERR     = 6'b100000;

  // Active-low segments, bit 0 = a ... bit 6 = g.
  localparam logic [6:0] SEG_TAG_A = 7'h08;
  localparam logic [6:0] SEG_TAG_B = 7'h03;
  localparam logic [6:0] SEG_TAG_O = 7'h23;
  localparam logic [6:0] SEG_TAG_R = 7'h2F;
  localparam logic [6:0] SEG_TAG_E = 7'h06;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [5:0] state_led(input state_e s);
    logic [5:0] led;
    led = 6'b000000;
    case (s)
      ST_LOAD_A:  led = LED_LOAD_A;
      ST_LOAD_B:  led = LED_LOAD_B;
      ST_LOAD_OP: led = LED_LOAD_OP;
      ST_EXEC:    led = LED_EXEC;
      ST_SHOW:    led = LED_SHOW;
      ST_ERR:     led = LED_ERR;
      default:    led = 6'b000000;
    endcase
    return led;
  endfunction

  function automatic logic [6:0] state_tag(input state_e s);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (s)
      ST_LOAD_A:  seg = SEG_TAG_A;
      ST_LOAD_B:  seg = SEG_TAG_B;
      ST_LOAD_OP: seg = SEG_TAG_O;
      ST_EXEC:    seg = SEG_DASH;
      ST_SHOW:    seg = SEG_TAG_R;
      ST_ERR:     seg = SEG_TAG_E;
      default:    seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] seg;
    seg = SEG_BLANK;
    case (n)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/alu_console_key_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability down-counter and a
// one-cycle press pulse when the accepted level falls. Releases are debounced
// the same way but produce no pulse, so a held key yields a single press.
module alu_console_key_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_n_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYC);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser; resets to the released (high) level so power-up is not a press.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
    end
  end

  // Count down while the synchronised level differs from the accepted one; accept at terminal count.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = CNT_LOAD;
    if (sync2_q != stable_q) begin
      if (cnt_q == '0) begin
        stable_d = sync2_q;
        press_d  = ~sync2_q;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // Accepted level, counter and press pulse registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stable_q <= 1'b1;
      press_q  <= 1'b0;
      cnt_q    <= CNT_LOAD;
    end else begin
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_console.sv
// Operator front-end for ALU bring-up: gathers A, B and opcode from the
// switches, runs one start/done transaction with timeout and shows the
// fields, result or error on the seven-segment displays.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   LOAD_A     | ENTER shifts SW[7:0] into A; NEXT -> LOAD_B
//   LOAD_B     | ENTER shifts SW[7:0] into B; NEXT -> LOAD_OP
//   LOAD_OP    | ENTER loads opcode; NEXT -> EXEC with alu_start pulse
//   EXEC       | keys ignored; done -> SHOW, timer expiry -> ERR
//   SHOW       | result and flags latched; NEXT -> LOAD_A for a re-run
//   ERR        | ALU timed out; NEXT -> LOAD_A for a re-run
module alu_console
  import alu_console_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int OP_W         = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int TIMEOUT_CYC  = 1024
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic [9:0]        SW,
  input  logic [2:0]        key_n,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flags,
  output logic [41:0]       hex,
  output logic [9:0]        LEDR
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  // Loaded with TIMEOUT_CYC-1 so the terminal count lands in the last cycle a done may arrive.
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [NUM_KEYS-1:0] press;
  logic                unused_sw;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [3:0]          flags_q, flags_d;
  logic                start_q, start_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [DATA_W+7:0]   shift_a, shift_b;
  logic [DATA_W-1:0]   field;
  logic                show_digits;

  assign unused_sw = ^SW[9:8];

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    alu_console_key_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key (
      .clk_i  (CLOCK_50),
      .rst_n_i(resetn),
      .key_n_i(key_n[k]),
      .press_o(press[k])
    );
  end

  assign shift_a = {a_q, SW[7:0]};
  assign shift_b = {b_q, SW[7:0]};

  // Next-state logic: EXEC owns the handshake, otherwise keys by priority CLEAR > NEXT > ENTER.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    start_d = 1'b0;
    tmo_d   = tmo_q;
    if (state_q == ST_EXEC) begin
      if (alu_done) begin
        state_d = ST_SHOW;
        res_d   = alu_result;
        flags_d = alu_flags;
      end else if (tmo_q == '0) begin
        state_d = ST_ERR;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end else if (press[KEY_CLEAR]) begin
      state_d = ST_LOAD_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      flags_d = '0;
    end else if (press[KEY_NEXT]) begin
      case (state_q)
        ST_LOAD_A:  state_d = ST_LOAD_B;
        ST_LOAD_B:  state_d = ST_LOAD_OP;
        ST_LOAD_OP: begin
          state_d = ST_EXEC;
          start_d = 1'b1;
          tmo_d   = TMO_LOAD;
        end
        ST_SHOW, ST_ERR: state_d = ST_LOAD_A;
        default: state_d = state_q;
      endcase
    end else if (press[KEY_ENTER]) begin
      case (state_q)
        ST_LOAD_A:  a_d  = shift_a[DATA_W-1:0];
        ST_LOAD_B:  b_d  = shift_b[DATA_W-1:0];
        ST_LOAD_OP: op_d = SW[OP_W-1:0];
        default:    op_d = op_q;
      endcase
    end
  end

  // State, operand and result registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      flags_q <= '0;
      start_q <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      start_q <= start_d;
      tmo_q   <= tmo_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign alu_start = start_q;
  assign LEDR      = {state_led(state_q), flags_q};

  // Display decode from the registered state: tag on HEX5, active field on the low digits.
  always_comb begin
    field       = '0;
    show_digits = 1'b1;
    case (state_q)
      ST_LOAD_A:  field = a_q;
      ST_LOAD_B:  field = b_q;
      ST_LOAD_OP: field[OP_W-1:0] = op_q;
      ST_SHOW:    field = res_q;
      default:    show_digits = 1'b0;
    endcase
    hex        = {6{SEG_BLANK}};
    hex[41:35] = state_tag(state_q);
    if (state_q == ST_ERR) begin
      hex[34:28] = SEG_TAG_R;
    end
    if (show_digits) begin
      for (int i = 0; i < DATA_W / 4; i++) begin
        hex[7*i +: 7] = hex_seg(field[4*i +: 4]);
      end
    end
  end

endmodule

// File: tb/tb_alu_console.sv
// Bench for alu_console: table of full transactions plus hand-written
// sequences for bounce, simultaneous keys and reset during EXEC.
module tb_alu_console;

  localparam int DW  = 16;
  localparam int OW  = 4;
  localparam int DB  = 4;
  localparam int TMO = 64;

  localparam logic [2:0] M_ENTER = 3'b001;
  localparam logic [2:0] M_NEXT  = 3'b010;
  localparam logic [2:0] M_CLEAR = 3'b100;

  localparam logic [6:0] T_A = 7'h08;
  localparam logic [6:0] T_B = 7'h03;
  localparam logic [6:0] T_O = 7'h23;
  localparam logic [6:0] T_R = 7'h2F;
  localparam logic [6:0] T_E = 7'h06;
  localparam logic [6:0] BL  = 7'h7F;
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  localparam logic [5:0] S_LOAD_A = 6'b000001;
  localparam logic [5:0] S_LOAD_B = 6'b000010;
  localparam logic [5:0] S_EXEC   = 6'b001000;
  localparam logic [5:0] S_SHOW   = 6'b010000;
  localparam logic [5:0] S_ERR    = 6'b100000;

  logic          clk = 1'b0;
  logic          resetn;
  logic [9:0]    SW;
  logic [2:0]    key_n;
  logic [DW-1:0] alu_a, alu_b;
  logic [OW-1:0] alu_op;
  logic          alu_start;
  logic          alu_done;
  logic [DW-1:0] alu_result;
  logic [3:0]    alu_flags;
  logic [41:0]   hex;
  logic [9:0]    LEDR;

  alu_console #(
    .DATA_W(DW), .OP_W(OW), .DEBOUNCE_CYC(DB), .TIMEOUT_CYC(TMO)
  ) dut (
    .CLOCK_50(clk), .resetn(resetn), .SW(SW), .key_n(key_n),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_done(alu_done), .alu_result(alu_result), .alu_flags(alu_flags),
    .hex(hex), .LEDR(LEDR)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a_hi, a_lo, b_hi, b_lo;
    logic [3:0]  op;
    int          delay;
    bit          do_done;
    logic [15:0] result;
    logic [3:0]  flags;
  } vec_t;

  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  op;
  } req_t;

  typedef struct {
    int          delay;
    bit          do_done;
    logic [15:0] result;
    logic [3:0]  flags;
  } resp_t;

  req_t  exp_q[$];
  resp_t resp_q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int start_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_start === 1'b1) start_cnt++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m);
    key_n = ~m;
    tick(8);
    key_n = 3'b111;
    tick(10);
  endtask

  function automatic logic [41:0] disp(input logic [6:0] t5, input logic [6:0] t4,
                                       input logic [15:0] v, input bit dig);
    logic [41:0] d;
    d = {t5, t4, {4{BL}}};
    if (dig) d[27:0] = {SEG[v[15:12]], SEG[v[11:8]], SEG[v[7:4]], SEG[v[3:0]]};
    return d;
  endfunction

  // ALU model: checks each start against the scoreboard and answers with the queued response.
  initial begin : alu_model
    req_t  q;
    resp_t r;
    alu_done = 1'b0;
    alu_result = '0;
    alu_flags = '0;
    forever begin
      @(negedge clk);
      if (alu_start === 1'b1) begin
        start_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got alu_start=1 expected no request pending");
        end else begin
          q = exp_q.pop_front();
          check("start_a", 64'(alu_a), 64'(q.a));
          check("start_b", 64'(alu_b), 64'(q.b));
          check("start_op", 64'(alu_op), 64'(q.op));
        end
        if (resp_q.size() > 0) begin
          r = resp_q.pop_front();
          if (r.do_done) begin
            repeat (r.delay) @(negedge clk);
            if (LEDR[7] === 1'b1) begin
              check("hold_a", 64'(alu_a), 64'(q.a));
              check("hold_op", 64'(alu_op), 64'(q.op));
            end
            alu_done = 1'b1;
            alu_result = r.result;
            alu_flags = r.flags;
            @(negedge clk);
            alu_done = 1'b0;
            alu_result = '0;
            alu_flags = '0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    vec_t        vecs[5];
    vec_t        v;
    logic [15:0] ea, eb;
    int          sc, n;
    bit          exp_show;

    vecs[0] = '{8'h12, 8'h34, 8'h00, 8'h05, 4'h3, 7,       1'b1, 16'h1239, 4'b0000};
    vecs[1] = '{8'hAB, 8'hCD, 8'hFF, 8'h01, 4'hF, 1,       1'b1, 16'hBEEF, 4'b1010};
    vecs[2] = '{8'h00, 8'h00, 8'h80, 8'h00, 4'h9, TMO - 1, 1'b1, 16'h0000, 4'b0100};
    vecs[3] = '{8'h12, 8'h34, 8'h00, 8'h05, 4'h3, 0,       1'b0, 16'h0000, 4'b0000};
    vecs[4] = '{8'h12, 8'h34, 8'h00, 8'h05, 4'h3, TMO,     1'b1, 16'h5555, 4'b1111};

    resetn = 1'b0;
    SW = '0;
    key_n = 3'b111;
    tick(3);
    resetn = 1'b1;
    tick(2);

    check("reset_ledr", 64'(LEDR), 64'(10'b0000010000));
    check("reset_hex", 64'(hex), 64'(disp(T_A, BL, 16'h0000, 1'b1)));
    check("reset_start", 64'(alu_start), 64'(1'b0));
    check("reset_a", 64'(alu_a), 64'h0);
    check("reset_b", 64'(alu_b), 64'h0);
    check("reset_op", 64'(alu_op), 64'h0);

    for (int i = 0; i < 5; i++) begin
      v = vecs[i];
      ea = {v.a_hi, v.a_lo};
      eb = {v.b_hi, v.b_lo};
      exp_show = v.do_done && (v.delay < TMO);
      press(M_CLEAR);
      SW = {2'b10, v.a_hi}; press(M_ENTER);
      SW = {2'b01, v.a_lo}; press(M_ENTER);
      check("load_a_disp", 64'(hex), 64'(disp(T_A, BL, ea, 1'b1)));
      press(M_NEXT);
      SW = {2'b11, v.b_hi}; press(M_ENTER);
      SW = {2'b00, v.b_lo}; press(M_ENTER);
      check("load_b_disp", 64'(hex), 64'(disp(T_B, BL, eb, 1'b1)));
      press(M_NEXT);
      SW = {2'b11, 4'hA, v.op}; press(M_ENTER);
      check("load_op_disp", 64'(hex), 64'(disp(T_O, BL, {12'h000, v.op}, 1'b1)));
      exp_q.push_back('{ea, eb, v.op});
      resp_q.push_back('{v.delay, v.do_done, v.result, v.flags});
      sc = start_cnt;
      press(M_NEXT);
      n = 0;
      while (!(LEDR[8] === 1'b1 || LEDR[9] === 1'b1) && n < 300) begin
        tick(1);
        n++;
      end
      check("result_wait_expired", 64'(n >= 300), 64'h0);
      check("start_count", 64'(start_cnt), 64'(sc + 1));
      if (exp_show) begin
        check("show_state", 64'(LEDR[9:4]), 64'(S_SHOW));
        check("show_hex", 64'(hex), 64'(disp(T_R, BL, v.result, 1'b1)));
        check("show_flags", 64'(LEDR[3:0]), 64'(v.flags));
      end else begin
        check("err_state", 64'(LEDR[9:4]), 64'(S_ERR));
        check("err_latency", 64'(cyc - start_cyc), 64'(TMO));
        check("err_hex", 64'(hex), 64'(disp(T_E, T_R, 16'h0000, 1'b0)));
        tick(5);
        check("err_late_done_state", 64'(LEDR[9:4]), 64'(S_ERR));
        check("err_late_done_flags", 64'(LEDR[3:0]), 64'h0);
      end
      press(M_NEXT);
      check("rerun_ledr", 64'(LEDR), 64'({S_LOAD_A, exp_show ? v.flags : 4'h0}));
      check("rerun_hex", 64'(hex), 64'(disp(T_A, BL, ea, 1'b1)));
    end

    // CLEAR and NEXT together in LOAD_B: CLEAR wins and zeroes everything.
    press(M_NEXT);
    check("to_load_b", 64'(LEDR[9:4]), 64'(S_LOAD_B));
    press(M_CLEAR | M_NEXT);
    check("clr_next_ledr", 64'(LEDR), 64'(10'b0000010000));
    check("clr_next_a", 64'(alu_a), 64'h0);
    check("clr_next_b", 64'(alu_b), 64'h0);
    check("clr_next_op", 64'(alu_op), 64'h0);
    check("clr_next_hex", 64'(hex), 64'(disp(T_A, BL, 16'h0000, 1'b1)));

    // ENTER bounce: low 2, high 1, low 10 gives a single shift.
    SW = 10'h05A;
    key_n[0] = 1'b0; tick(2);
    key_n[0] = 1'b1; tick(1);
    key_n[0] = 1'b0; tick(10);
    key_n[0] = 1'b1; tick(12);
    check("bounce_one_shift", 64'(alu_a), 64'h005A);
    SW = 10'h03C;
    key_n[0] = 1'b0; tick(1000);
    key_n[0] = 1'b1; tick(12);
    check("held_one_shift", 64'(alu_a), 64'h5A3C);

    // Reset during EXEC, then a late done from the ALU.
    press(M_CLEAR);
    SW = 10'h001; press(M_ENTER);
    press(M_NEXT);
    press(M_NEXT);
    SW = 10'h001; press(M_ENTER);
    exp_q.push_back('{16'h0001, 16'h0000, 4'h1});
    resp_q.push_back('{30, 1'b1, 16'hFFFF, 4'hF});
    press(M_NEXT);
    check("exec_before_reset", 64'(LEDR[9:4]), 64'(S_EXEC));
    resetn = 1'b0;
    tick(1);
    check("rst_exec_start", 64'(alu_start), 64'(1'b0));
    check("rst_exec_ledr_now", 64'(LEDR), 64'(10'b0000010000));
    tick(1);
    resetn = 1'b1;
    tick(40);
    check("late_done_ledr", 64'(LEDR), 64'(10'b0000010000));
    check("late_done_hex", 64'(hex), 64'(disp(T_A, BL, 16'h0000, 1'b1)));
    check("late_done_a", 64'(alu_a), 64'h0);
    check("late_done_op", 64'(alu_op), 64'h0);
    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
